// File: rtl/dbg_mem_arbiter.sv
// Arbitrates the single system memory port between the core data port and the
// debug memory-access path, with starvation relief for debug and a debug timeout.
module dbg_mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned DBG_TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dbg_halted,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dbg_rd_en,
    input  logic              dbg_wr_en,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ready,
    output logic              dbg_busy,
    output logic [1:0]        dbg_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TW = (DBG_TIMEOUT > 1) ? $clog2(DBG_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_XFER = 2'd1,
        DBG_XFER = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dbg_cmd_t;

    state_t          state;
    dbg_cmd_t        pend;
    logic            pend_valid;
    logic [SW-1:0]   starve_cnt;
    logic [TW-1:0]   to_cnt;

    logic dbg_pulse;
    logic accept;
    logic drop;
    logic grant_dbg;
    logic to_last;

    // A new command is only taken when nothing is pending and no completion is being reported.
    assign dbg_pulse = dbg_rd_en | dbg_wr_en;
    assign accept    = dbg_pulse & ~pend_valid & ~dbg_ready;
    assign drop      = dbg_pulse & ~accept;
    assign grant_dbg = pend_valid & (dbg_halted | ~cpu_req | (starve_cnt == SW'(STARVE_LIMIT)));
    assign to_last   = (to_cnt == TW'(DBG_TIMEOUT - 1));

    assign cpu_ready = (state == CPU_XFER) & mem_ready;
    assign cpu_rdata = cpu_ready ? mem_rdata : '0;
    assign dbg_busy  = pend_valid;

    // Arbiter FSM with registered memory-port and debug outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pend       <= '0;
            pend_valid <= 1'b0;
            starve_cnt <= '0;
            to_cnt     <= '0;
            dbg_rdata  <= '0;
            dbg_ready  <= 1'b0;
            dbg_err    <= 2'b00;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            dbg_ready <= 1'b0;

            if (accept) begin
                pend.we    <= dbg_wr_en;
                pend.addr  <= dbg_addr;
                pend.wdata <= dbg_wdata;
                pend_valid <= 1'b1;
                dbg_err    <= 2'b00;
            end else if (drop) begin
                dbg_err[1] <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (grant_dbg) begin
                        state      <= DBG_XFER;
                        starve_cnt <= '0;
                        to_cnt     <= '0;
                        mem_req    <= 1'b1;
                        mem_we     <= pend.we;
                        mem_addr   <= pend.addr;
                        mem_wdata  <= pend.wdata;
                    end else if (cpu_req) begin
                        state     <= CPU_XFER;
                        mem_req   <= 1'b1;
                        mem_we    <= cpu_we;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        if (!pend_valid) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
                            starve_cnt <= SW'(starve_cnt + 1'b1);
                        end
                    end
                end

                CPU_XFER: begin
                    if (mem_ready) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                    end
                end

                DBG_XFER: begin
                    if (mem_ready || to_last) begin
                        state      <= IDLE;
                        pend_valid <= 1'b0;
                        dbg_ready  <= 1'b1;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_addr   <= '0;
                        mem_wdata  <= '0;
                        if (mem_ready) begin
                            if (!pend.we) begin
                                dbg_rdata <= mem_rdata;
                            end
                        end else begin
                            dbg_err[0] <= 1'b1;
                        end
                    end else begin
                        to_cnt <= TW'(to_cnt + 1'b1);
                    end
                end

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_mem_arbiter.sv
// Directed self-checking bench for dbg_mem_arbiter; inputs are driven and outputs
// sampled on the falling clock edge.
module tb_dbg_mem_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              dbg_halted;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              dbg_rd_en;
    logic              dbg_wr_en;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ready;
    logic              dbg_busy;
    logic [1:0]        dbg_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dbg_mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (4),
        .DBG_TIMEOUT  (255)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dbg_halted (dbg_halted),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .dbg_rd_en  (dbg_rd_en),
        .dbg_wr_en  (dbg_wr_en),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_rdata  (dbg_rdata),
        .dbg_ready  (dbg_ready),
        .dbg_busy   (dbg_busy),
        .dbg_err    (dbg_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance until mem_req is seen, at most max_cyc falling edges.
    task automatic wait_req(input string tag, input int max_cyc);
        int n = 0;
        while (!mem_req && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_grant"}, 64'(mem_req), 64'(1));
    endtask

    initial begin
        int cpu_grants;
        int hi_cycles;
        int seen_ready;

        rst_n      = 1'b0;
        dbg_halted = 1'b0;
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        dbg_rd_en  = 1'b0;
        dbg_wr_en  = 1'b0;
        dbg_addr   = '0;
        dbg_wdata  = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_mem_req",   64'(mem_req),   64'(0));
        chk("rst_dbg_busy",  64'(dbg_busy),  64'(0));
        chk("rst_dbg_err",   64'(dbg_err),   64'(0));
        chk("rst_dbg_ready", 64'(dbg_ready), 64'(0));
        chk("rst_dbg_rdata", 64'(dbg_rdata), 64'(0));
        chk("rst_cpu_ready", 64'(cpu_ready), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 1: plain CPU read on an idle system
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0100;
        @(negedge clk);
        chk("t1_mem_req",  64'(mem_req),  64'(1));
        chk("t1_mem_addr", 64'(mem_addr), 64'(32'h100));
        chk("t1_mem_we",   64'(mem_we),   64'(0));
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_0001;
        cpu_req   = 1'b0;
        #1;
        chk("t1_cpu_ready", 64'(cpu_ready), 64'(1));
        chk("t1_cpu_rdata", 64'(cpu_rdata), 64'(32'hCAFE_0001));
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("t1_cpu_ready_pulse", 64'(cpu_ready), 64'(0));
        chk("t1_mem_req_drop",    64'(mem_req),   64'(0));

        // 2: halted core, debug write wins over a waiting CPU request
        dbg_halted = 1'b1;
        dbg_wr_en  = 1'b1;
        dbg_addr   = 32'h2000_0000;
        dbg_wdata  = 32'h0000_1234;
        @(negedge clk);
        dbg_wr_en = 1'b0;
        chk("t2_busy",      64'(dbg_busy), 64'(1));
        chk("t2_no_req_yet", 64'(mem_req), 64'(0));
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h0000_0300;
        cpu_wdata = 32'h0000_0055;
        @(negedge clk);
        chk("t2_dbg_req",   64'(mem_req),   64'(1));
        chk("t2_dbg_we",    64'(mem_we),    64'(1));
        chk("t2_dbg_addr",  64'(mem_addr),  64'(32'h2000_0000));
        chk("t2_dbg_wdata", 64'(mem_wdata), 64'(32'h1234));
        mem_ready = 1'b1;
        #1;
        chk("t2_no_cpu_ready", 64'(cpu_ready), 64'(0));
        @(negedge clk);
        mem_ready = 1'b0;
        chk("t2_dbg_ready", 64'(dbg_ready), 64'(1));
        chk("t2_gap",       64'(mem_req),   64'(0));
        chk("t2_busy_clr",  64'(dbg_busy),  64'(0));
        chk("t2_rdata_kept", 64'(dbg_rdata), 64'(0));
        @(negedge clk);
        chk("t2_cpu_req",   64'(mem_req),  64'(1));
        chk("t2_cpu_addr",  64'(mem_addr), 64'(32'h300));
        chk("t2_cpu_wdata", 64'(mem_wdata), 64'(32'h55));
        chk("t2_dbg_ready_pulse", 64'(dbg_ready), 64'(0));
        mem_ready = 1'b1;
        cpu_req   = 1'b0;
        #1;
        chk("t2_cpu_ready", 64'(cpu_ready), 64'(1));
        @(negedge clk);
        mem_ready  = 1'b0;
        dbg_halted = 1'b0;
        chk("t2_idle", 64'(mem_req), 64'(0));

        // 3: running core with continuous CPU traffic; debug read after 4 CPU grants
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0400;
        @(negedge clk);
        chk("t3_first_cpu", 64'(mem_req), 64'(1));
        dbg_rd_en = 1'b1;
        dbg_addr  = 32'h3000_0040;
        @(negedge clk);
        dbg_rd_en = 1'b0;
        chk("t3_busy", 64'(dbg_busy), 64'(1));
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready  = 1'b0;
        cpu_grants = 0;
        for (int g = 0; g < 8; g++) begin
            wait_req("t3", 8);
            if (mem_addr == 32'h3000_0040) break;
            cpu_grants++;
            mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0;
        end
        chk("t3_cpu_grants", 64'(cpu_grants), 64'(4));
        chk("t3_dbg_addr",   64'(mem_addr),   64'(32'h3000_0040));
        chk("t3_dbg_we",     64'(mem_we),     64'(0));
        mem_rdata = 32'hD00D_BEEF;
        mem_ready = 1'b1;
        cpu_req   = 1'b0;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("t3_dbg_ready", 64'(dbg_ready), 64'(1));
        chk("t3_dbg_rdata", 64'(dbg_rdata), 64'(32'hD00D_BEEF));
        @(negedge clk);
        chk("t3_dbg_ready_pulse", 64'(dbg_ready), 64'(0));
        chk("t3_idle",            64'(mem_req),   64'(0));

        // 4: debug read never answered; aborted after 255 cycles
        dbg_halted = 1'b1;
        dbg_rd_en  = 1'b1;
        dbg_addr   = 32'h0000_0044;
        mem_rdata  = 32'h1111_2222;
        @(negedge clk);
        dbg_rd_en = 1'b0;
        @(negedge clk);
        hi_cycles = 0;
        while (mem_req && hi_cycles < 400) begin
            hi_cycles++;
            @(negedge clk);
        end
        chk("t4_req_cycles", 64'(hi_cycles), 64'(255));
        chk("t4_dbg_ready",  64'(dbg_ready), 64'(1));
        chk("t4_dbg_err",    64'(dbg_err),   64'(2'b01));
        chk("t4_busy_clr",   64'(dbg_busy),  64'(0));
        chk("t4_rdata_kept", 64'(dbg_rdata), 64'(32'hD00D_BEEF));
        @(negedge clk);
        chk("t4_ready_pulse", 64'(dbg_ready), 64'(0));
        chk("t4_idle",        64'(mem_req),   64'(0));

        // 5: command dropped while busy; first command unaffected; error cleared on next accept
        dbg_wr_en = 1'b1;
        dbg_addr  = 32'h0000_0500;
        dbg_wdata = 32'h0000_AAAA;
        @(negedge clk);
        chk("t5_err_cleared", 64'(dbg_err),  64'(0));
        chk("t5_busy",        64'(dbg_busy), 64'(1));
        dbg_addr  = 32'h0000_0600;
        dbg_wdata = 32'h0000_BBBB;
        @(negedge clk);
        dbg_wr_en = 1'b0;
        chk("t5_drop_err", 64'(dbg_err),   64'(2'b10));
        chk("t5_addr",     64'(mem_addr),  64'(32'h500));
        chk("t5_wdata",    64'(mem_wdata), 64'(32'hAAAA));
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("t5_dbg_ready", 64'(dbg_ready), 64'(1));
        dbg_rd_en = 1'b1;
        dbg_addr  = 32'h0000_0650;
        @(negedge clk);
        chk("t5_ready_cycle_drop", 64'(dbg_busy), 64'(0));
        chk("t5_err_still",        64'(dbg_err),  64'(2'b10));
        dbg_addr = 32'h0000_0700;
        @(negedge clk);
        dbg_rd_en = 1'b0;
        chk("t5_accept_clr", 64'(dbg_err),  64'(0));
        chk("t5_accept",     64'(dbg_busy), 64'(1));
        @(negedge clk);
        chk("t5_xfer",      64'(mem_req),  64'(1));
        chk("t5_xfer_addr", 64'(mem_addr), 64'(32'h700));

        // 6: asynchronous reset in the middle of a debug transfer
        rst_n = 1'b0;
        #1;
        chk("t6_req_async",  64'(mem_req),  64'(0));
        chk("t6_busy_async", 64'(dbg_busy), 64'(0));
        @(negedge clk);
        rst_n      = 1'b1;
        mem_ready  = 1'b1;
        seen_ready = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (dbg_ready || mem_req) seen_ready++;
        end
        mem_ready = 1'b0;
        chk("t6_no_ready", 64'(seen_ready), 64'(0));
        chk("t6_err",      64'(dbg_err),    64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
